// File: rtl/video_mode_ctl.sv
// Screen-mode controller: decodes menu button clicks, runs the MENU/GAME/CREDITS
// state machine, holds difficulty/theme, and muxes one renderer channel to VGA.
module video_mode_ctl #(
  parameter int N_CH        = 3,
  parameter int DIFF_LEVELS = 2,
  parameter int THEMES      = 7,
  parameter int BTN_X_MIN   = 362,
  parameter int BTN_X_MAX   = 674,
  parameter int BTN_Y_FIRST = 46,
  parameter int BTN_PITCH   = 192,
  parameter int BTN_H       = 100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [11:0]        xpos,
  input  logic [9:0]         ypos,
  input  logic               mouse_left,
  input  logic               button,
  input  logic               vblnk_in,
  input  logic [12*N_CH-1:0] rgb_in,
  input  logic [N_CH-1:0]    hsync_in,
  input  logic [N_CH-1:0]    vsync_in,
  output logic [11:0]        rgb_out,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic [1:0]         sel,
  output logic               start,
  output logic [3:0]         difficulty,
  output logic [11:0]        color1,
  output logic [11:0]        color2
);

  typedef enum logic [1:0] {MENU, GAME, CREDITS} state_t;

  state_t      state;
  logic [2:0]  theme;
  logic        btn_s1, btn_s2, btn_s3;
  logic        mouse_prev;
  logic        vblnk_d1, vblnk_d2;
  logic        back, click, tick;
  logic        x_in;
  logic [11:0] y_ext;
  logic [3:0]  hit;
  logic [1:0]  state_ch;

  assign back  = btn_s2 & ~btn_s3;
  assign click = mouse_left & ~mouse_prev;
  assign tick  = vblnk_d1 & ~vblnk_d2;
  assign y_ext = {2'b00, ypos};
  assign x_in  = (xpos >= 12'(BTN_X_MIN)) && (xpos <= 12'(BTN_X_MAX));

  always_comb begin
    hit = '0;
    for (int k = 0; k < 4; k++) begin
      hit[k] = x_in &&
               (y_ext >= 12'(BTN_Y_FIRST + k*BTN_PITCH)) &&
               (y_ext <= 12'(BTN_Y_FIRST + k*BTN_PITCH + BTN_H));
    end
  end

  always_comb begin
    state_ch = 2'd0;
    case (state)
      GAME:    state_ch = 2'd1;
      CREDITS: state_ch = 2'd2;
      default: state_ch = 2'd0;
    endcase
  end

  // The pushbutton is asynchronous; the third flop only serves edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1     <= 1'b0;
      btn_s2     <= 1'b0;
      btn_s3     <= 1'b0;
      mouse_prev <= 1'b0;
      vblnk_d1   <= 1'b0;
      vblnk_d2   <= 1'b0;
    end else begin
      btn_s1     <= button;
      btn_s2     <= btn_s1;
      btn_s3     <= btn_s2;
      mouse_prev <= mouse_left;
      vblnk_d1   <= vblnk_in;
      vblnk_d2   <= vblnk_d1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= MENU;
      difficulty <= 4'd0;
      theme      <= 3'd0;
    end else begin
      case (state)
        MENU: begin
          if (click) begin
            if (hit[0]) begin
              state <= GAME;
            end else if (hit[3]) begin
              state <= CREDITS;
            end else if (hit[1]) begin
              difficulty <= (difficulty == 4'(DIFF_LEVELS-1)) ? 4'd0 : difficulty + 4'd1;
            end else if (hit[2]) begin
              theme <= (theme == 3'(THEMES-1)) ? 3'd0 : theme + 3'd1;
            end
          end
        end
        GAME, CREDITS: begin
          if (back) state <= MENU;
        end
        default: state <= MENU;
      endcase
    end
  end

  // The mux only follows the mode at frame boundaries so a frame is never split.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel   <= 2'd0;
      start <= 1'b0;
    end else if (tick) begin
      sel   <= state_ch;
      start <= (state_ch == 2'd1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_out   <= 12'h000;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      rgb_out   <= rgb_in[sel*12 +: 12];
      hsync_out <= hsync_in[sel];
      vsync_out <= vsync_in[sel];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      color1 <= 12'h000;
      color2 <= 12'hFFF;
    end else begin
      case (theme)
        3'd0:    begin color1 <= 12'h000; color2 <= 12'hFFF; end
        3'd1:    begin color1 <= 12'h099; color2 <= 12'hF66; end
        3'd2:    begin color1 <= 12'h909; color2 <= 12'h6F6; end
        3'd3:    begin color1 <= 12'h990; color2 <= 12'h66F; end
        3'd4:    begin color1 <= 12'h339; color2 <= 12'hFF6; end
        3'd5:    begin color1 <= 12'h933; color2 <= 12'h6FF; end
        3'd6:    begin color1 <= 12'h393; color2 <= 12'hF6F; end
        default: begin color1 <= 12'h555; color2 <= 12'hFF0; end
      endcase
    end
  end

endmodule

// File: tb/tb_video_mode_ctl.sv
// Scoreboard bench for video_mode_ctl: stimulus pushes time-stamped expectations
// from a mode/menu reference model, a negedge monitor pops and compares them.
module tb_video_mode_ctl;

  localparam int N_CH        = 3;
  localparam int DIFF_LEVELS = 2;
  localparam int THEMES      = 7;

  logic                clk = 1'b0;
  logic                rst;
  logic [11:0]         xpos;
  logic [9:0]          ypos;
  logic                mouse_left;
  logic                button;
  logic                vblnk_in;
  logic [12*N_CH-1:0]  rgb_in;
  logic [N_CH-1:0]     hsync_in;
  logic [N_CH-1:0]     vsync_in;
  logic [11:0]         rgb_out;
  logic                hsync_out;
  logic                vsync_out;
  logic [1:0]          sel;
  logic                start;
  logic [3:0]          difficulty;
  logic [11:0]         color1;
  logic [11:0]         color2;

  video_mode_ctl #(.N_CH(N_CH), .DIFF_LEVELS(DIFF_LEVELS), .THEMES(THEMES)) dut (
    .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos), .mouse_left(mouse_left),
    .button(button), .vblnk_in(vblnk_in), .rgb_in(rgb_in), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .rgb_out(rgb_out), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .sel(sel), .start(start), .difficulty(difficulty),
    .color1(color1), .color2(color2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef enum int {F_RGB, F_HS, F_VS, F_SEL, F_START, F_DIFF, F_C1, F_C2} field_t;
  typedef struct {
    int          due;
    field_t      field;
    logic [11:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  sb_entry_t mon_e;

  // Reference model: the mode is 0=menu, 1=game, 2=credits and doubles as the channel.
  int ref_mode, ref_diff, ref_theme, ref_sel;
  logic [11:0] ch_rgb [N_CH];
  logic        ch_hs  [N_CH];
  logic        ch_vs  [N_CH];
  logic [11:0] theme_c1 [8] = '{12'h000, 12'h099, 12'h909, 12'h990, 12'h339, 12'h933, 12'h393, 12'h555};
  logic [11:0] theme_c2 [8] = '{12'hFFF, 12'hF66, 12'h6F6, 12'h66F, 12'hFF6, 12'h6FF, 12'hF6F, 12'hFF0};

  task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      case (mon_e.field)
        F_RGB:   checkOutput("rgb_out",    rgb_out,             mon_e.exp);
        F_HS:    checkOutput("hsync_out",  {11'b0, hsync_out},  mon_e.exp);
        F_VS:    checkOutput("vsync_out",  {11'b0, vsync_out},  mon_e.exp);
        F_SEL:   checkOutput("sel",        {10'b0, sel},        mon_e.exp);
        F_START: checkOutput("start",      {11'b0, start},      mon_e.exp);
        F_DIFF:  checkOutput("difficulty", {8'b0, difficulty},  mon_e.exp);
        F_C1:    checkOutput("color1",     color1,              mon_e.exp);
        default: checkOutput("color2",     color2,              mon_e.exp);
      endcase
    end
  end

  function automatic void push_exp(input int due, input field_t f, input logic [11:0] v);
    sb_entry_t e;
    e.due = due; e.field = f; e.exp = v;
    sb.push_back(e);
  endfunction

  function automatic int hit_index(input int x, input int y);
    int k;
    if (x < 362 || x > 674 || y < 46) return -1;
    k = (y - 46) / 192;
    if (k > 3) return -1;
    if ((y - 46) - k*192 > 100) return -1;
    return k;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_channels();
    for (int k = 0; k < N_CH; k++) begin
      rgb_in[12*k +: 12] = ch_rgb[k];
      hsync_in[k]        = ch_hs[k];
      vsync_in[k]        = ch_vs[k];
    end
  endtask

  task automatic push_outputs(input int due);
    push_exp(due, F_RGB, ch_rgb[ref_sel]);
    push_exp(due, F_HS,  {11'b0, ch_hs[ref_sel]});
    push_exp(due, F_VS,  {11'b0, ch_vs[ref_sel]});
  endtask

  task automatic do_click(input int x, input int y, input int hold);
    int k, c0;
    xpos = 12'(x); ypos = 10'(y); mouse_left = 1'b1;
    c0 = cyc;
    k = hit_index(x, y);
    if (ref_mode == 0) begin
      if (k == 0)      ref_mode = 1;
      else if (k == 3) ref_mode = 2;
      else if (k == 1) ref_diff = (ref_diff + 1) % DIFF_LEVELS;
      else if (k == 2) ref_theme = (ref_theme + 1) % THEMES;
    end
    push_exp(c0 + 1, F_DIFF, 12'(ref_diff));
    push_exp(c0 + 2, F_C1, theme_c1[ref_theme]);
    push_exp(c0 + 2, F_C2, theme_c2[ref_theme]);
    push_exp(c0 + 2, F_SEL, 12'(ref_sel));
    step(hold);
    mouse_left = 1'b0;
    push_exp(cyc + 1, F_DIFF, 12'(ref_diff));
    step(2);
  endtask

  task automatic do_back(input int hold);
    button = 1'b1;
    step(hold);
    button = 1'b0;
    step(5);
    ref_mode = 0;
    push_exp(cyc + 1, F_SEL, 12'(ref_sel));
  endtask

  task automatic do_frame(input int hold);
    int c0;
    vblnk_in = 1'b1;
    c0 = cyc;
    push_exp(c0 + 1, F_SEL, 12'(ref_sel));
    ref_sel = ref_mode;
    push_exp(c0 + 2, F_SEL, 12'(ref_sel));
    push_exp(c0 + 2, F_START, {11'b0, ref_sel == 1});
    push_outputs(c0 + 3);
    step(hold);
    vblnk_in = 1'b0;
    step(3);
  endtask

  task automatic do_rgb();
    for (int k = 0; k < N_CH; k++) begin
      ch_rgb[k] = 12'($urandom);
      ch_hs[k]  = 1'($urandom);
      ch_vs[k]  = 1'($urandom);
    end
    drive_channels();
    push_outputs(cyc + 1);
    step(2);
  endtask

  // One randomized operation, including boundary and near-miss click positions.
  task automatic applyStimulus();
    int op, kind, k, m, x, y, top;
    op = $urandom_range(0, 9);
    if (op < 4) begin
      kind = $urandom_range(0, 5);
      k = $urandom_range(0, 3);
      top = 46 + k*192;
      case ($urandom_range(0, 2))
        0: x = 362;
        1: x = 674;
        default: x = $urandom_range(362, 674);
      endcase
      case ($urandom_range(0, 2))
        0: y = top;
        1: y = top + 100;
        default: y = top + $urandom_range(0, 100);
      endcase
      if (kind < 4) begin
        y = 46 + kind*192 + (y - top);
      end else if (kind == 4) begin
        x = $urandom_range(0, 1100);
        y = $urandom_range(0, 1023);
      end else begin
        m = $urandom_range(0, 3);
        if (m == 0)      x = 361;
        else if (m == 1) x = 675;
        else if (m == 2) y = top - 1;
        else             y = top + 101;
      end
      do_click(x, y, $urandom_range(1, 8));
    end else if (op < 6) begin
      do_back($urandom_range(1, 4));
    end else if (op < 8) begin
      do_frame($urandom_range(1, 4));
    end else begin
      do_rgb();
    end
  endtask

  task automatic check_reset_now();
    checkOutput("rst_rgb_out",    rgb_out,             12'h000);
    checkOutput("rst_hsync_out",  {11'b0, hsync_out},  12'h000);
    checkOutput("rst_vsync_out",  {11'b0, vsync_out},  12'h000);
    checkOutput("rst_sel",        {10'b0, sel},        12'h000);
    checkOutput("rst_start",      {11'b0, start},      12'h000);
    checkOutput("rst_difficulty", {8'b0, difficulty},  12'h000);
    checkOutput("rst_color1",     color1,              12'h000);
    checkOutput("rst_color2",     color2,              12'hFFF);
  endtask

  task automatic release_reset();
    step(2);
    rst = 1'b0;
    ref_mode = 0; ref_diff = 0; ref_theme = 0; ref_sel = 0;
    push_outputs(cyc + 1);
    push_exp(cyc + 1, F_SEL, 12'h000);
    push_exp(cyc + 1, F_START, 12'h000);
    push_exp(cyc + 1, F_C1, 12'h000);
    push_exp(cyc + 1, F_C2, 12'hFFF);
    step(3);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (sb.size() > 0 && budget < 20) begin
      step(1);
      budget++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    rst = 1'b1;
    xpos = '0; ypos = '0; mouse_left = 1'b0; button = 1'b0; vblnk_in = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      ch_rgb[k] = 12'(12'h100 * (k + 1));
      ch_hs[k]  = 1'b0;
      ch_vs[k]  = 1'b0;
    end
    drive_channels();
    #3;
    check_reset_now();
    release_reset();

    $display("[TB] difficulty cycling with a long hold");
    do_click(400, 250, 50);
    do_click(400, 250, 3);

    $display("[TB] theme cycling");
    for (int i = 0; i < 8; i++) do_click(500, 450, 2);

    $display("[TB] enter game mid-frame, then frame tick");
    do_click(400, 100, 2);
    do_click(400, 250, 2);
    step(4);
    do_frame(3);

    $display("[TB] back to menu, then credits");
    do_back(2);
    do_frame(2);
    do_click(400, 650, 2);
    do_frame(2);

    $display("[TB] state change on the tick cycle");
    do_back(3);
    do_frame(2);
    begin
      int c0;
      vblnk_in = 1'b1;
      c0 = cyc;
      ref_sel = ref_mode;
      push_exp(c0 + 2, F_SEL, 12'(ref_sel));
      push_exp(c0 + 2, F_START, {11'b0, ref_sel == 1});
      step(1);
      xpos = 12'd400; ypos = 10'd100; mouse_left = 1'b1;
      ref_mode = 1;
      step(2);
      mouse_left = 1'b0;
      vblnk_in = 1'b0;
      push_exp(cyc + 1, F_SEL, 12'(ref_sel));
      step(3);
    end
    do_frame(2);

    $display("[TB] randomized phase");
    for (int i = 0; i < 250; i++) applyStimulus();

    $display("[TB] async reset in credits with theme 3");
    do_back(2);
    do_frame(2);
    for (int i = 0; i < 8 && ref_theme != 3; i++) do_click(500, 450, 2);
    do_click(400, 650, 2);
    do_frame(2);
    do_rgb();
    drain();
    #2;
    rst = 1'b1;
    #1;
    check_reset_now();
    release_reset();
    for (int i = 0; i < 40; i++) applyStimulus();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_mode_ctl.md
Name: video_mode_ctl

Overview:
Parametrised screen-mode controller and video channel multiplexer that sits between the timing generator/screen renderers and the VGA output register stage. Decodes edge-detected mouse clicks on a stacked menu button column and runs the MENU/GAME/CREDITS state machine. Cycles difficulty and colour theme with configurable wrap limits. Drives the theme colour pair and the game start flag, and selects one of N_CH renderer channels, switching only at frame boundaries.

Parameters:
N_CH, 3, number of renderer channels (0=menu, 1=game, 2=credits, others unused; min 3)
DIFF_LEVELS, 2, number of difficulty levels (1..16)
THEMES, 7, number of colour themes used (1..8)
BTN_X_MIN, 362, left edge of menu button column, inclusive
BTN_X_MAX, 674, right edge of menu button column, inclusive
BTN_Y_FIRST, 46, top edge of button 0
BTN_PITCH, 192, vertical distance between button tops
BTN_H, 100, button height (bottom = top+BTN_H, inclusive)

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous, active-high reset
xpos  in  12  mouse x
ypos  in  10  mouse y
mouse_left  in  1  left mouse button level
button  in  1  back-to-menu pushbutton level (asynchronous to clk)
vblnk_in  in  1  vertical blank from timing generator
rgb_in  in  12*N_CH  packed channel colours, channel k at [12k+11:12k]
hsync_in  in  N_CH  per-channel hsync
vsync_in  in  N_CH  per-channel vsync
rgb_out  out  12  selected colour, registered
hsync_out  out  1  selected hsync, registered
vsync_out  out  1  selected vsync, registered
sel  out  2  active channel index
start  out  1  high while the game channel is active
difficulty  out  4  current difficulty (0..DIFF_LEVELS-1)
color1  out  12  theme background colour
color2  out  12  theme foreground colour

Behaviour:
- Reset (async, rst=1): state=MENU, sel=0, difficulty=0, theme=0, start=0, rgb_out=0, hsync_out=0, vsync_out=0, edge/sync registers=0; color1=000, color2=FFF.
- button passes through a 2-flop synchroniser. back = rising edge of the synchronised level.
- click = mouse_left rising edge (1-cycle pulse). Holding the button never repeats an action.
- Button k hit: xpos in [BTN_X_MIN,BTN_X_MAX] and ypos in [BTN_Y_FIRST+k*BTN_PITCH, that+BTN_H], k=0..3. Compare ypos zero-extended to 12 bits.
- FSM:
  - MENU: click on btn0 -> GAME; click on btn3 -> CREDITS.
  - MENU, click on btn1: difficulty <= (difficulty==DIFF_LEVELS-1) ? 0 : difficulty+1.
  - MENU, click on btn2: theme <= (theme==THEMES-1) ? 0 : theme+1.
  - MENU, back is ignored.
  - GAME or CREDITS: back -> MENU. Clicks are ignored; difficulty and theme are frozen.
  - Click outside all buttons: no effect.
- Frame tick = rising edge of registered vblnk_in. On tick, sel <= channel of the current registered state (MENU=0, GAME=1, CREDITS=2). sel holds between ticks.
- A state change on the tick cycle is picked up at the next tick. Mid-frame changes never switch the mux.
- start = (sel==1), registered with sel.
- Output: rgb_out/hsync_out/vsync_out <= channel sel of the inputs, 1-cycle latency from inputs.
- Theme table (color1/color2):
  - 0: 000/FFF
  - 1: 099/F66
  - 2: 909/6F6
  - 3: 990/66F
  - 4: 339/FF6
  - 5: 933/6FF
  - 6: 393/F6F
  - 7: 555/FF0
- color1/color2 are registered from theme and update the cycle after theme changes.
- THEMES=1 or DIFF_LEVELS=1: the corresponding value stays 0.

Test Plan:
- Reset, then drive rgb_in channel k = 12'h100*(k+1) -> rgb_out=100, sel=0, start=0, color1/color2=000/FFF.
- In MENU, hold mouse_left high 50 cycles at (400,250) -> difficulty 0->1 exactly once; second click -> 0 (wraps at DIFF_LEVELS=2).
- Eight clicks at (500,450) -> theme sequence 1,2,3,4,5,6,0,1; color1/color2 match the table one cycle after each change.
- Click at (400,100) mid-frame -> state GAME, sel stays 0 until the next vblnk_in rise, then sel=1, start=1, rgb_out=200 one cycle later. Click at (400,250) during GAME -> difficulty unchanged.
- In GAME, pulse button -> MENU after sync latency; sel=0 at next frame tick. Click at (400,650) -> CREDITS, then sel=2 and rgb_out=300 after a tick.
- Assert rst asynchronously mid-frame while in CREDITS with theme=3 -> all outputs are reset-valued immediately, without waiting for a clk edge.
